am9513_cai_comp_writer: RTL and testbench

CAI completion-ring writer for the Am9513/Am9514 accelerator. It sits directly downstream of the execute engine. For each finished job it takes the completion tuple (tag, status, ext_status, bytes_written), writes a 16-byte v1 completion record into the memory ring at `comp_base + (head & mask) * 16`, then pulses `comp_msg`. The pulse is issued only after every beat of the record has been acknowledged, so software or a bench can read the record on the `comp_msg` cycle.

---
 rtl/am9513_pkg.sv | 47 ++++
 rtl/carbon_arch_pkg.sv | 8 +
 rtl/am9513_cai_comp_writer.sv | 198 +++++++++++++++++++
 tb/tb_am9513_cai_comp_writer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am9513_pkg.sv
// am9513_pkg: shared definitions for the Am9513 CAI completion-ring writer.
//   - record beat count and field byte offsets of the v1 completion record
//   - slot shift derived from the architectural record size
//   - FSM state type and a helper that builds the write data for one beat
package am9513_pkg;

    import carbon_arch_pkg::*;

    localparam int unsigned AM9513_COMP_REC_BEATS = 4;

    // log2 of the record size: the ring slot index is shifted by this amount.
    localparam int unsigned AM9513_COMP_SLOT_SHIFT =
        $clog2(CARBON_CAI_COMP_REC_V1_SIZE_BYTES);

    // Byte offsets of the 32-bit fields inside a record.
    localparam logic [3:0] AM9513_COMP_OFF_TAG    = 4'h0;
    localparam logic [3:0] AM9513_COMP_OFF_STATUS = 4'h4;
    localparam logic [3:0] AM9513_COMP_OFF_BYTES  = 4'h8;
    localparam logic [3:0] AM9513_COMP_OFF_RSVD   = 4'hC;

    typedef enum logic [2:0] {
        CW_IDLE   = 3'd0,
        CW_REQ    = 3'd1,
        CW_RSP    = 3'd2,
        CW_NOTIFY = 3'd3,
        CW_ERR    = 3'd4
    } cw_state_e;

    // Write data for the beat at byte offset 'off' of the record.
    function automatic logic [31:0] am9513_comp_rec_word(
        input logic [3:0]  off,
        input logic [31:0] tag,
        input logic [15:0] status,
        input logic [15:0] ext,
        input logic [31:0] bytes
    );
        logic [31:0] w;
        case (off)
            AM9513_COMP_OFF_TAG:    w = tag;
            AM9513_COMP_OFF_STATUS: w = {ext, status};
            AM9513_COMP_OFF_BYTES:  w = bytes;
            default:                w = 32'h0;  // reserved word
        endcase
        return w;
    endfunction

endpackage : am9513_pkg

// File: rtl/carbon_arch_pkg.sv
// carbon_arch_pkg: architecture-wide constants shared by the Carbon blocks.
// Only the v1 completion-record size is needed by the CAI completion writer.
package carbon_arch_pkg;

    // Size in bytes of one v1 CAI completion record (one ring slot).
    localparam int unsigned CARBON_CAI_COMP_REC_V1_SIZE_BYTES = 16;

endpackage : carbon_arch_pkg

// File: rtl/am9513_cai_comp_writer.sv
// am9513_cai_comp_writer: CAI completion-ring writer.
//
// Accepts one completion tuple at a time from the execute engine, writes the
// 16-byte v1 record as four 32-bit beats to comp_base + (head & mask) * 16,
// and pulses comp_msg once every beat has been acknowledged.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   enable                      writer enable, sampled in IDLE; low clears head/error
//   comp_base/comp_mask/comp_tail  ring base, index mask, consumer index
//   irq_enable, irq_ack         interrupt enable and write-1 clear
//   comp_valid/comp_ready       completion handshake, with comp_tag/status/ext/bytes
//   mem_req_*                   one-beat write request (valid/ready)
//   mem_rsp_valid/mem_rsp_err   write response
//   comp_msg                    one-cycle pulse: record committed
//   comp_head                   producer index
//   comp_wr_err                 sticky write-error flag
//   irq                         completion interrupt
//   dbg_state                   current FSM state (debug visibility)
//
// Configuration macro: AM9513_CAI_COMP_IRQ_EN enables the interrupt logic;
// without it irq is tied low.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once mem_req_valid is raised, address and data stay stable until
// the transfer; comp_ready never depends on comp_valid.
module am9513_cai_comp_writer
    import am9513_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] comp_base,
    input  logic [31:0]       comp_mask,
    input  logic [31:0]       comp_tail,
    input  logic              irq_enable,
    input  logic              irq_ack,
    input  logic              comp_valid,
    output logic              comp_ready,
    input  logic [31:0]       comp_tag,
    input  logic [15:0]       comp_status,
    input  logic [15:0]       comp_ext,
    input  logic [31:0]       comp_bytes,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_rsp_valid,
    input  logic              mem_rsp_err,
    output logic              comp_msg,
    output logic [31:0]       comp_head,
    output logic              comp_wr_err,
    output logic              irq,
    output logic [2:0]        dbg_state
);

    localparam logic [1:0] LAST_BEAT = 2'(AM9513_COMP_REC_BEATS - 1);

    cw_state_e         state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [31:0]       head_q, head_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] rec_addr_q, rec_addr_d;
    logic [31:0]       tag_q, tag_d;
    logic [15:0]       status_q, status_d;
    logic [15:0]       ext_q, ext_d;
    logic [31:0]       bytes_q, bytes_d;

    logic              full;
    logic              ready_w;
    logic [3:0]        beat_off;
    logic [31:0]       slot_idx;

    // Modular difference keeps the occupancy correct across a 2^32 wrap.
    assign full     = (head_q - comp_tail) > comp_mask;
    assign ready_w  = (state_q == CW_IDLE) && enable && !full && !err_q;
    assign slot_idx = head_q & comp_mask;
    assign beat_off = {beat_q, 2'b00};

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        head_d     = head_q;
        err_d      = err_q;
        rec_addr_d = rec_addr_q;
        tag_d      = tag_q;
        status_d   = status_q;
        ext_d      = ext_q;
        bytes_d    = bytes_q;
        case (state_q)
            CW_IDLE: begin
                if (!enable) begin
                    head_d = '0;
                    err_d  = 1'b0;
                end else if (comp_valid && ready_w) begin
                    tag_d      = comp_tag;
                    status_d   = comp_status;
                    ext_d      = comp_ext;
                    bytes_d    = comp_bytes;
                    rec_addr_d = comp_base
                               + (ADDR_W'(slot_idx) << AM9513_COMP_SLOT_SHIFT);
                    beat_d     = '0;
                    state_d    = CW_REQ;
                end
            end
            CW_REQ: begin
                if (mem_req_ready) state_d = CW_RSP;
            end
            CW_RSP: begin
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        state_d = CW_ERR;
                    end else if (beat_q == LAST_BEAT) begin
                        state_d = CW_NOTIFY;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        state_d = CW_REQ;
                    end
                end
            end
            CW_NOTIFY: begin
                head_d  = head_q + 32'd1;
                state_d = CW_IDLE;
            end
            CW_ERR: begin
                // Head is left untouched; the writer stays blocked on err_q
                // until enable is dropped.
                err_d   = 1'b1;
                state_d = CW_IDLE;
            end
            default: state_d = CW_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CW_IDLE;
            beat_q     <= '0;
            head_q     <= '0;
            err_q      <= 1'b0;
            rec_addr_q <= '0;
            tag_q      <= '0;
            status_q   <= '0;
            ext_q      <= '0;
            bytes_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            head_q     <= head_d;
            err_q      <= err_d;
            rec_addr_q <= rec_addr_d;
            tag_q      <= tag_d;
            status_q   <= status_d;
            ext_q      <= ext_d;
            bytes_q    <= bytes_d;
        end
    end

    assign comp_ready    = ready_w;
    assign mem_req_valid = (state_q == CW_REQ);
    assign mem_req_addr  = rec_addr_q + ADDR_W'(beat_off);
    assign mem_req_wdata = am9513_comp_rec_word(beat_off, tag_q, status_q,
                                                ext_q, bytes_q);
    assign mem_req_wstrb = 4'hF;
    assign comp_msg      = (state_q == CW_NOTIFY);
    assign comp_head     = head_q;
    assign comp_wr_err   = err_q;
    assign dbg_state     = state_q;

`ifdef AM9513_CAI_COMP_IRQ_EN
    logic irq_q, irq_d;

    // Setting on NOTIFY takes priority over a simultaneous acknowledge.
    always_comb begin
        irq_d = irq_q;
        if ((state_q == CW_NOTIFY) && irq_enable) begin
            irq_d = 1'b1;
        end else if (irq_ack || !enable) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = irq_enable | irq_ack;
    assign irq = 1'b0;
`endif

endmodule : am9513_cai_comp_writer

// File: tb/tb_am9513_cai_comp_writer.sv
// tb_am9513_cai_comp_writer: scoreboard bench for the CAI completion writer.
// Stimulus pushes expected records (address, words, head, accept cycle) into
// exp_q; a monitor pops and checks them against the bench memory whenever the
// DUT pulses comp_msg. A fabric process models a one-outstanding write port
// with optional stalls, random backpressure and error injection.
module tb_am9513_cai_comp_writer;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] head;
    logic [31:0] t0;
    logic        lat;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        enable;
  logic [63:0] comp_base;
  logic [31:0] comp_mask, comp_tail;
  logic        irq_enable, irq_ack;
  logic        comp_valid, comp_ready;
  logic [31:0] comp_tag;
  logic [15:0] comp_status, comp_ext;
  logic [31:0] comp_bytes;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid, mem_rsp_err;
  logic        comp_msg;
  logic [31:0] comp_head;
  logic        comp_wr_err, irq;
  logic [2:0]  dbg_state;

  am9513_cai_comp_writer #(.ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .comp_base(comp_base), .comp_mask(comp_mask), .comp_tail(comp_tail),
    .irq_enable(irq_enable), .irq_ack(irq_ack),
    .comp_valid(comp_valid), .comp_ready(comp_ready),
    .comp_tag(comp_tag), .comp_status(comp_status), .comp_ext(comp_ext),
    .comp_bytes(comp_bytes),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_err(mem_rsp_err),
    .comp_msg(comp_msg), .comp_head(comp_head), .comp_wr_err(comp_wr_err),
    .irq(irq), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  exp_t        exp_q[$];
  logic [31:0] mem[logic [63:0]];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_head = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  // ---------------- fabric model ----------------
  bit          rand_ready = 0;
  int          stall_beat = -1;
  int          stall_left = 0;
  int          err_beat   = -1;
  int          stall_holds = 0;
  bit          hs_pend = 0;
  bit          in_stall = 0;
  logic [63:0] hs_addr, last_addr;
  logic [31:0] hs_data, last_data;
  int          hs_beat, beat;

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      if (!rst_n) begin
        hs_pend = 0;
        in_stall = 0;
        mem_req_ready = 1'b0;
      end else begin
        if (hs_pend) begin
          mem[hs_addr]  = hs_data;
          mem_rsp_valid = 1'b1;
          mem_rsp_err   = (hs_beat == err_beat);
          hs_pend       = 0;
        end
        if (in_stall && !mem_req_valid) chk("req_valid_dropped", 0, 1);
        if (mem_req_valid) begin
          beat = int'(mem_req_addr[3:2]);
          if (in_stall) begin
            chk("stall_addr_stable", mem_req_addr, last_addr);
            chk("stall_data_stable", mem_req_wdata, last_data);
            stall_holds++;
          end
          if (stall_beat == beat && stall_left > 0) begin
            mem_req_ready = 1'b0;
            stall_left--;
            in_stall = 1;
          end else if (rand_ready && $urandom_range(0, 2) == 0) begin
            mem_req_ready = 1'b0;
            in_stall = 1;
          end else begin
            mem_req_ready = 1'b1;
            in_stall = 0;
            hs_pend  = 1;
            hs_addr  = mem_req_addr;
            hs_data  = mem_req_wdata;
            hs_beat  = beat;
            chk("wstrb", mem_req_wstrb, 4'hF);
          end
          last_addr = mem_req_addr;
          last_data = mem_req_wdata;
        end else begin
          mem_req_ready = 1'($urandom_range(0, 1));
          in_stall = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && comp_msg === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_msg: comp_msg with head %0d, required no record", comp_head);
        end else begin
          e = exp_q.pop_front();
          chk("record_words", {rd(e.addr), rd(e.addr + 4), rd(e.addr + 8), rd(e.addr + 12)},
              {e.w0, e.w1, e.w2, e.w3});
          chk("msg_head", comp_head, e.head);
          if (e.lat) chk("msg_latency", cyc - e.t0, 9);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] tag, input logic [15:0] st, input logic [15:0] ext,
                      input logic [31:0] bytes, input bit ok, input bit lat);
    int n;
    exp_t e;
    @(negedge clk);
    comp_valid  = 1'b1;
    comp_tag    = tag;
    comp_status = st;
    comp_ext    = ext;
    comp_bytes  = bytes;
    n = 0;
    while (comp_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (comp_ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: comp_ready %b, required 1", comp_ready);
      comp_valid = 1'b0;
      return;
    end
    if (ok) begin
      e.addr = comp_base + 64'(m_head & comp_mask) * 64'd16;
      e.head = m_head;
      e.t0   = cyc;
      e.lat  = lat;
      e.w0   = tag;
      e.w1   = {ext, st};
      e.w2   = bytes;
      e.w3   = 32'h0;
      exp_q.push_back(e);
      m_head = m_head + 1;
    end
    @(negedge clk);
    comp_valid = 1'b0;
  endtask

  task automatic send_rand(input bit lat);
    send($urandom, 16'($urandom), 16'($urandom), $urandom, 1, lat);
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: %0d records pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic restart();
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    m_head = 0;
    enable = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] last_tag;
    rst_n = 1'b0;
    enable = 1'b0; comp_base = '0; comp_mask = '0; comp_tail = '0;
    irq_enable = 1'b0; irq_ack = 1'b0;
    comp_valid = 1'b0; comp_tag = '0; comp_status = '0; comp_ext = '0; comp_bytes = '0;
    repeat (3) @(negedge clk);
    chk("rst_comp_ready", comp_ready, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_req_wdata", mem_req_wdata, 0);
    chk("rst_wstrb", mem_req_wstrb, 4'hF);
    chk("rst_msg", comp_msg, 0);
    chk("rst_head", comp_head, 0);
    chk("rst_wr_err", comp_wr_err, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;

    // basic record
    @(negedge clk);
    enable = 1'b1; comp_base = 64'h500; comp_mask = 15; comp_tail = 0;
    send(32'h1, 16'h0, 16'h0, 32'd16, 1, 1);
    wait_done();
    chk("basic_head", comp_head, 1);
    chk("basic_w0", rd(64'h500), 32'h1);
    chk("basic_w1", rd(64'h504), 32'h0);
    chk("basic_w2", rd(64'h508), 32'h10);
    chk("basic_w3", rd(64'h50C), 32'h0);

    // wrap: 16 more with tail tracking head
    last_tag = 0;
    for (int i = 0; i < 16; i++) begin
      comp_tail = m_head;
      last_tag = $urandom;
      send(last_tag, 16'($urandom), 16'($urandom), $urandom, 1, 1);
    end
    wait_done();
    chk("wrap_head", comp_head, 17);
    chk("wrap_slot0_tag", rd(64'h500), last_tag);

    // full backpressure
    restart();
    comp_mask = 3; comp_tail = 0;
    for (int i = 0; i < 4; i++) send_rand(1);
    wait_done();
    comp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_ready_low", comp_ready, ((m_head - comp_tail) <= comp_mask) ? 1 : 0);
    end
    comp_valid = 1'b0;
    comp_tail = 1;
    last_tag = $urandom;
    send(last_tag, 16'h5, 16'h6, 32'h77, 1, 1);
    wait_done();
    chk("full_slot0_tag", rd(64'h500), last_tag);
    chk("full_head", comp_head, 5);

    // fabric stall on beat 2
    comp_mask = 15; comp_tail = m_head;
    stall_holds = 0; stall_beat = 2; stall_left = 5;
    send_rand(0);
    wait_done();
    stall_beat = -1;
    chk("stall_hold_cycles", stall_holds, 5);

    // randomized traffic with random backpressure and random base/occupancy
    rand_ready = 1;
    comp_base = {$urandom, 28'($urandom), 4'h0};
    for (int i = 0; i < 24; i++) begin
      irq_enable = 1'($urandom_range(0, 1));
      comp_tail = m_head - $urandom_range(0, int'(comp_mask));
      send_rand(0);
    end
    wait_done();
    rand_ready = 0;
    chk("rand_head", comp_head, m_head);

    // write error on beat 1
    irq_enable = 1'b0;
    restart();
    comp_base = 64'h500; comp_tail = 0;
    send_rand(1);
    wait_done();
    err_beat = 1;
    send($urandom, 16'h1, 16'h2, 32'h3, 0, 0);
    repeat (40) @(negedge clk);
    err_beat = -1;
    chk("err_flag", comp_wr_err, 1);
    chk("err_head", comp_head, 1);
    chk("err_blocked", comp_ready, 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("err_clr_head", comp_head, 0);
    chk("err_clr_flag", comp_wr_err, 0);
    m_head = 0;
    enable = 1'b1;
    comp_tail = 0;
    send_rand(1);
    wait_done();
    chk("err_recover_head", comp_head, 1);

    // interrupt
`ifdef AM9513_CAI_COMP_IRQ_EN
    irq_enable = 1'b1;
    send_rand(1);
    wait_done();
    chk("irq_set", irq, 1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    @(negedge clk);
    chk("irq_ack_clr", irq, 0);
    irq_enable = 1'b0;
    send_rand(1);
    wait_done();
    chk("irq_disabled", irq, 0);
`else
    irq_enable = 1'b1;
    send_rand(1);
    wait_done();
    chk("irq_tied_low", irq, 0);
    irq_enable = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_am9513_cai_comp_writer
